// File: rtl/stage_mem_ws.sv
// MEM pipeline stage: data memory with configurable wait states, upstream stall
// while an access is pending, and the MEM/WB pipeline register.
module stage_mem_ws #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int REG_W       = 3,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_MEM,
  input  logic              flush_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              ResultSrc_MEM,
  input  logic              RegWrite_MEM,
  input  logic [REG_W-1:0]  rd_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] write_data_MEM,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              ResultSrc_WB,
  output logic              RegWrite_WB,
  output logic              valid_WB,
  output logic [REG_W-1:0]  rd_WB,
  output logic [REG_W-1:0]  rd_WB_d,
  output logic              addr_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              mem_op, complete, bad_addr;
  logic [ADDR_W-1:0] addr;

  assign mem_op   = valid_MEM & (MemRead_MEM | MemWrite_MEM) & ~flush_MEM;
  assign addr     = alu_result_MEM[ADDR_W-1:0];
  // Any address bit above the memory's range marks the access as out of bounds.
  assign bad_addr = |(alu_result_MEM >> ADDR_W);
  assign rd_WB    = rd_MEM;

  // NOTE: every output of this always_comb gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_MEM = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (HAS_WAIT) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
            stall_MEM = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!mem_op) begin
          // Flushed (or withdrawn) mid-access: abandon without touching memory.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_nxt   = cnt - 4'd1;
          stall_MEM = 1'b1;
        end else begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
    if (!reset) stall_MEM = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the memory array is reset word by word because a cleared memory is part of the reset state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && MemWrite_MEM && !bad_addr) begin
      mem[addr] <= write_data_MEM;
    end
  end

  // MEM/WB register: a stall inserts a bubble and holds the data fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_out   <= '0;
      alu_result_out <= '0;
      ResultSrc_WB   <= 1'b0;
      RegWrite_WB    <= 1'b0;
      valid_WB       <= 1'b0;
      rd_WB_d        <= '0;
      addr_err       <= 1'b0;
    end else begin
      addr_err <= complete & bad_addr;
      if (!stall_MEM) begin
        alu_result_out <= alu_result_MEM;
        ResultSrc_WB   <= ResultSrc_MEM;
        rd_WB_d        <= rd_MEM;
        valid_WB       <= valid_MEM & ~flush_MEM;
        RegWrite_WB    <= RegWrite_MEM & valid_MEM & ~flush_MEM;
        // Reading before the same-edge write returns the old word on read+write.
        if (complete && MemRead_MEM)
          mem_data_out <= bad_addr ? '0 : mem[addr];
      end else begin
        valid_WB    <= 1'b0;
        RegWrite_WB <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_ws.sv
// Self-checking bench for stage_mem_ws: directed scenarios plus random ops
// checked against a transaction-level memory model.
module tb_stage_mem_ws;
  localparam int DW = 8, AW = 4, RW = 3, WS = 2;

  logic clk = 1'b0;
  logic reset;
  logic valid_MEM, flush_MEM, MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM;
  logic [RW-1:0] rd_MEM;
  logic [DW-1:0] alu_result_MEM, write_data_MEM;
  logic stall_MEM, ResultSrc_WB, RegWrite_WB, valid_WB, addr_err;
  logic [DW-1:0] mem_data_out, alu_result_out;
  logic [RW-1:0] rd_WB, rd_WB_d;

  logic z_valid, z_flush, z_mr, z_mw, z_rs, z_rw;
  logic [RW-1:0] z_rd;
  logic [DW-1:0] z_alu, z_wd;
  logic z_stall, z_rswb, z_rwwb, z_vwb, z_aerr;
  logic [DW-1:0] z_mdo, z_aro;
  logic [RW-1:0] z_rdwb, z_rdwbd;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model_mem [2**AW];

  stage_mem_ws #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .valid_MEM(valid_MEM), .flush_MEM(flush_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM),
    .RegWrite_MEM(RegWrite_MEM), .rd_MEM(rd_MEM), .alu_result_MEM(alu_result_MEM),
    .write_data_MEM(write_data_MEM), .stall_MEM(stall_MEM), .mem_data_out(mem_data_out),
    .alu_result_out(alu_result_out), .ResultSrc_WB(ResultSrc_WB), .RegWrite_WB(RegWrite_WB),
    .valid_WB(valid_WB), .rd_WB(rd_WB), .rd_WB_d(rd_WB_d), .addr_err(addr_err)
  );

  stage_mem_ws #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .valid_MEM(z_valid), .flush_MEM(z_flush),
    .MemRead_MEM(z_mr), .MemWrite_MEM(z_mw), .ResultSrc_MEM(z_rs),
    .RegWrite_MEM(z_rw), .rd_MEM(z_rd), .alu_result_MEM(z_alu),
    .write_data_MEM(z_wd), .stall_MEM(z_stall), .mem_data_out(z_mdo),
    .alu_result_out(z_aro), .ResultSrc_WB(z_rswb), .RegWrite_WB(z_rwwb),
    .valid_WB(z_vwb), .rd_WB(z_rdwb), .rd_WB_d(z_rdwbd), .addr_err(z_aerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":stall"},  stall_MEM,      0);
    check({tag, ":mdo"},    mem_data_out,   0);
    check({tag, ":alu"},    alu_result_out, 0);
    check({tag, ":rs"},     ResultSrc_WB,   0);
    check({tag, ":rw"},     RegWrite_WB,    0);
    check({tag, ":valid"},  valid_WB,       0);
    check({tag, ":rd_d"},   rd_WB_d,        0);
    check({tag, ":aerr"},   addr_err,       0);
  endtask

  // One instruction on the WS=2 instance; expectations come from the memory model.
  task automatic run_op(input string tag, input logic rd_e, input logic wr_e, input logic rw,
                        input logic rs, input logic [RW-1:0] rdi, input logic [DW-1:0] alu,
                        input logic [DW-1:0] wd);
    int n;
    logic bad_a;
    logic [DW-1:0] exp_ld;
    logic [AW-1:0] a;
    valid_MEM = 1'b1; flush_MEM = 1'b0; MemRead_MEM = rd_e; MemWrite_MEM = wr_e;
    RegWrite_MEM = rw; ResultSrc_MEM = rs; rd_MEM = rdi; alu_result_MEM = alu; write_data_MEM = wd;
    n      = (rd_e | wr_e) ? WS : 0;
    bad_a  = (alu >> AW) != 0;
    a      = alu[AW-1:0];
    exp_ld = bad_a ? '0 : model_mem[a];
    for (int i = 0; i <= n; i++) begin
      #1;
      check({tag, ":stall"}, stall_MEM, 32'(i < n));
      check({tag, ":rd_WB"}, rd_WB, rdi);
      @(posedge clk); #1;
      if (i < n) begin
        check({tag, ":bubble_valid"}, valid_WB, 0);
        check({tag, ":bubble_rw"},    RegWrite_WB, 0);
        check({tag, ":bubble_aerr"},  addr_err, 0);
      end
    end
    check({tag, ":valid_WB"}, valid_WB, 1);
    check({tag, ":RegWrite_WB"}, RegWrite_WB, rw);
    check({tag, ":ResultSrc_WB"}, ResultSrc_WB, rs);
    check({tag, ":rd_WB_d"}, rd_WB_d, rdi);
    check({tag, ":alu_out"}, alu_result_out, alu);
    check({tag, ":addr_err"}, addr_err, 32'((rd_e | wr_e) & bad_a));
    if (rd_e) check({tag, ":load"}, mem_data_out, exp_ld);
    if (wr_e && !bad_a) model_mem[a] = wd;
  endtask

  task automatic idle_inputs();
    valid_MEM = 0; flush_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
    ResultSrc_MEM = 0; RegWrite_MEM = 0; rd_MEM = '0; alu_result_MEM = '0; write_data_MEM = '0;
  endtask

  initial begin
    logic [DW-1:0] r_alu;
    int kind;
    reset = 1'b0;
    idle_inputs();
    z_valid = 0; z_flush = 0; z_mr = 0; z_mw = 0; z_rs = 0; z_rw = 0;
    z_rd = '0; z_alu = '0; z_wd = '0;
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    check("por:z_valid", z_vwb, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance: back-to-back store then load of address 1.
    z_valid = 1; z_mw = 1; z_alu = 8'h01; z_wd = 8'h11; z_rd = 3'd1;
    #1 check("ws0_st:stall", z_stall, 0);
    @(posedge clk); #1;
    z_mw = 0; z_mr = 1; z_rw = 1; z_rs = 1;
    #1 check("ws0_ld:stall", z_stall, 0);
    @(posedge clk); #1;
    check("ws0_ld:data", z_mdo, 8'h11);
    check("ws0_ld:valid", z_vwb, 1);
    z_valid = 0; z_mr = 0; z_rw = 0; z_rs = 0;

    // Wait-state store then load, ALU op, and out-of-range store.
    run_op("st_a5", 0, 1, 0, 0, 3'd0, 8'h05, 8'hA5);
    run_op("ld_a5", 1, 0, 1, 1, 3'd2, 8'h05, 8'h00);
    check("ld_a5:direct", mem_data_out, 8'hA5);
    run_op("alu", 0, 0, 1, 0, 3'd4, 8'h3C, 8'h00);
    run_op("st_bad", 0, 1, 0, 0, 3'd0, 8'h20, 8'h77);
    run_op("alu_hi", 0, 0, 0, 0, 3'd1, 8'hF0, 8'h00);
    run_op("ld0", 1, 0, 1, 1, 3'd1, 8'h00, 8'h00);
    check("ld0:direct", mem_data_out, 8'h00);

    // Flush in the 2nd stall cycle of a store to address 2.
    valid_MEM = 1; MemWrite_MEM = 1; RegWrite_MEM = 1; alu_result_MEM = 8'h02;
    write_data_MEM = 8'h77; rd_MEM = 3'd5;
    #1 check("fl:stall1", stall_MEM, 1);
    @(posedge clk); #1;
    check("fl:bubble", valid_WB, 0);
    #1 check("fl:stall2", stall_MEM, 1);
    flush_MEM = 1;
    #1 check("fl:stall_drop", stall_MEM, 0);
    @(posedge clk); #1;
    check("fl:valid", valid_WB, 0);
    check("fl:rw", RegWrite_WB, 0);
    check("fl:alu_cap", alu_result_out, 8'h02);
    flush_MEM = 0;
    run_op("fl_ld", 1, 0, 1, 1, 3'd3, 8'h02, 8'h00);
    check("fl_ld:direct", mem_data_out, 8'h00);

    // Read+write in one access returns the old word.
    run_op("rmw", 1, 1, 1, 1, 3'd6, 8'h05, 8'h5A);
    check("rmw:old", mem_data_out, 8'hA5);

    // Random traffic against the model.
    for (int k = 0; k < 40; k++) begin
      kind  = $urandom_range(0, 3);
      r_alu = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) r_alu = 8'($urandom_range(16, 255));
      run_op("rnd", (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
             1'($urandom), 1'($urandom), 3'($urandom), r_alu, 8'($urandom));
    end

    // Reset asserted while a store is pending clears memory and outputs.
    run_op("st_3", 0, 1, 1, 0, 3'd7, 8'h03, 8'h3C);
    valid_MEM = 1; MemWrite_MEM = 1; alu_result_MEM = 8'h03; write_data_MEM = 8'hEE;
    #1 reset = 1'b0;
    #1 check_reset_state("mid_rst");
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    run_op("ld_3", 1, 0, 1, 1, 3'd2, 8'h03, 8'h00);
    check("ld_3:direct", mem_data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
